// File: rtl/cell_sequencer_if.sv
// Pixel-source and window-datapath signals of cell_sequencer.
// The slave modport is the sequencer; the master modport is the pixel source and datapath side.
interface cell_sequencer_if;
   logic       iPixValid;
   logic       iSof;
   logic [8:0] iRGB;
   logic       oEn;
   logic [8:0] oRGB;
   logic       oWinValid;
   logic [9:0] oCol;
   logic [9:0] oRow;
   logic       oBorder;
   logic       oEof;
   logic       oSyncErr;
   logic       oOverrun;

   modport master (
      output iPixValid, iSof, iRGB,
      input  oEn, oRGB, oWinValid, oCol, oRow, oBorder, oEof, oSyncErr, oOverrun
   );

   modport slave (
      input  iPixValid, iSof, iRGB,
      output oEn, oRGB, oWinValid, oCol, oRow, oBorder, oEof, oSyncErr, oOverrun
   );
endinterface

// File: rtl/cell_sequencer.sv
// Sequencer for the 3x3 window datapath: forwards source pixels as enables, flushes black pixels
// at end of frame, and tracks the window-centre coordinate.
module cell_sequencer #(
   parameter int unsigned WIDTH  = 640,
   parameter int unsigned HEIGHT = 480,
   parameter int unsigned LAG    = WIDTH + 1
) (
   input  logic             iClk27,
   input  logic             iRst,
   cell_sequencer_if.slave  bus
);

   localparam logic [1:0]  IDLE  = 2'd0;
   localparam logic [1:0]  RUN   = 2'd1;
   localparam logic [1:0]  FLUSH = 2'd2;

   localparam logic [19:0] PIX_LAST   = 20'(WIDTH * HEIGHT - 1);
   localparam logic [19:0] LAG_N      = 20'(LAG);
   localparam logic [19:0] FLUSH_LAST = 20'(LAG - 1);
   localparam logic [9:0]  COL_LAST   = 10'(WIDTH - 1);
   localparam logic [9:0]  ROW_LAST   = 10'(HEIGHT - 1);

   logic [1:0]  state;
   logic [19:0] nIn;
   logic [19:0] nEn;
   logic [19:0] nFlush;
   logic        winNext;
   logic [9:0]  cCol;
   logic [9:0]  cRow;

   logic        en;
   logic [8:0]  rgb;
   logic        winValid;
   logic [9:0]  col;
   logic [9:0]  row;
   logic        border;
   logic        eof;
   logic        syncErr;
   logic        overrun;

   logic accept;
   logic sofStart;
   logic earlySof;
   logic issue;

   assign sofStart = bus.iPixValid & bus.iSof & (state != FLUSH);
   assign earlySof = bus.iPixValid & bus.iSof & (state == RUN);
   assign accept   = bus.iPixValid & ((state == RUN) | ((state == IDLE) & bus.iSof));
   assign issue    = accept | (state == FLUSH);

   always_ff @(posedge iClk27 or posedge iRst) begin
      if (iRst) begin
         state    <= IDLE;
         nIn      <= '0;
         nEn      <= '0;
         nFlush   <= '0;
         winNext  <= 1'b0;
         cCol     <= '0;
         cRow     <= '0;
         en       <= 1'b0;
         rgb      <= '0;
         winValid <= 1'b0;
         col      <= '0;
         row      <= '0;
         border   <= 1'b0;
         eof      <= 1'b0;
         syncErr  <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         en      <= issue;
         rgb     <= accept ? bus.iRGB : '0;
         syncErr <= earlySof;
         overrun <= (state == FLUSH) & bus.iPixValid;

         // An early SOF kills the window still in flight from the aborted frame.
         winValid <= winNext & ~earlySof;
         eof      <= winNext & ~earlySof & (cCol == COL_LAST) & (cRow == ROW_LAST);
         if (winNext) begin
            col    <= cCol;
            row    <= cRow;
            border <= (cCol == '0) | (cCol == COL_LAST) | (cRow == '0) | (cRow == ROW_LAST);
            if (cCol == COL_LAST) begin
               cCol <= '0;
               cRow <= (cRow == ROW_LAST) ? '0 : cRow + 10'd1;
            end else begin
               cCol <= cCol + 10'd1;
            end
         end

         winNext <= issue & (nEn >= LAG_N) & ~sofStart;
         if (issue) nEn <= nEn + 20'd1;

         // Restart overrides the advance above; a pending final window still reads the old centre.
         if (sofStart) begin
            nEn  <= 20'd1;
            cCol <= '0;
            cRow <= '0;
         end

         case (state)
            IDLE: begin
               if (sofStart) begin
                  state <= RUN;
                  nIn   <= 20'd1;
               end
            end
            RUN: begin
               if (bus.iPixValid) begin
                  if (bus.iSof) begin
                     nIn <= 20'd1;
                  end else if (nIn == PIX_LAST) begin
                     state  <= FLUSH;
                     nFlush <= '0;
                  end else begin
                     nIn <= nIn + 20'd1;
                  end
               end
            end
            FLUSH: begin
               if (nFlush == FLUSH_LAST) state <= IDLE;
               else nFlush <= nFlush + 20'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.oEn       = en;
   assign bus.oRGB      = rgb;
   assign bus.oWinValid = winValid;
   assign bus.oCol      = col;
   assign bus.oRow      = row;
   assign bus.oBorder   = border;
   assign bus.oEof      = eof;
   assign bus.oSyncErr  = syncErr;
   assign bus.oOverrun  = overrun;

endmodule

// File: tb/tb_cell_sequencer.sv
// Directed bench for cell_sequencer on an 8x4 frame: cycle table for the contiguous frame,
// hand-written sequences for random gaps, early SOF, flush overrun and mid-frame reset.
module tb_cell_sequencer;
   localparam int W    = 8;
   localparam int H    = 4;
   localparam int LAG  = 9;
   localparam int NPIX = W * H;
   localparam int NVEC = NPIX + LAG + 5;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cell_sequencer_if bus();

   cell_sequencer #(.WIDTH(W), .HEIGHT(H), .LAG(LAG)) dut (
      .iClk27 (clk),
      .iRst   (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       pv;
      logic       sof;
      logic [8:0] rgb;
      logic       expEn;
      logic [8:0] expRGB;
      logic       expWin;
      logic [9:0] expCol;
      logic [9:0] expRow;
      logic       expBorder;
      logic       expEof;
   } vec_t;

   vec_t        tbl[NVEC];
   int          checks = 0;
   int          errors = 0;
   logic [8:0]  enQ[$];
   logic [21:0] winQ[$];
   int          syncCnt, ovrCnt, eofCnt;

   function automatic logic [8:0] pix(input int i);
      return 9'((i * 53 + 7) % 511 + 1);
   endfunction

   // {eof, border, row, col} of the idx-th raster centre
   function automatic logic [21:0] winExp(input int idx);
      int c, r;
      logic b;
      c = idx % W;
      r = idx / W;
      b = (c == 0) || (c == W - 1) || (r == 0) || (r == H - 1);
      return {(idx == NPIX - 1), b, 10'(r), 10'(c)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic pv, input logic sof, input logic [8:0] rgb);
      bus.iPixValid = pv;
      bus.iSof      = sof;
      bus.iRGB      = rgb;
   endtask

   task automatic clearLog();
      enQ.delete();
      winQ.delete();
      syncCnt = 0;
      ovrCnt  = 0;
      eofCnt  = 0;
   endtask

   task automatic step(input logic pv, input logic sof, input logic [8:0] rgb);
      @(negedge clk);
      if (bus.oEn) enQ.push_back(bus.oRGB);
      if (bus.oWinValid) winQ.push_back({bus.oEof, bus.oBorder, bus.oRow, bus.oCol});
      syncCnt += int'(bus.oSyncErr);
      ovrCnt  += int'(bus.oOverrun);
      eofCnt  += int'(bus.oEof);
      drive(pv, sof, rgb);
   endtask

   function automatic logic [63:0] allOuts();
      return 64'({bus.oEn, bus.oRGB, bus.oWinValid, bus.oCol, bus.oRow,
                  bus.oBorder, bus.oEof, bus.oSyncErr, bus.oOverrun});
   endfunction

   task automatic runTable(input string tag);
      vec_t v;
      for (int t = 0; t < NVEC; t++) begin
         @(negedge clk);
         v = tbl[t];
         check($sformatf("%s.t%0d.en", tag, t), bus.oEn, v.expEn);
         if (v.expEn) check($sformatf("%s.t%0d.rgb", tag, t), bus.oRGB, v.expRGB);
         check($sformatf("%s.t%0d.win", tag, t), bus.oWinValid, v.expWin);
         if (v.expWin) begin
            check($sformatf("%s.t%0d.col", tag, t), bus.oCol, v.expCol);
            check($sformatf("%s.t%0d.row", tag, t), bus.oRow, v.expRow);
            check($sformatf("%s.t%0d.border", tag, t), bus.oBorder, v.expBorder);
         end
         check($sformatf("%s.t%0d.eof", tag, t), bus.oEof, v.expEof);
         check($sformatf("%s.t%0d.errs", tag, t), {bus.oSyncErr, bus.oOverrun}, 2'b00);
         drive(v.pv, v.sof, v.rgb);
      end
   endtask

   task automatic checkStream(input string tag, input int oldPix, input int oldWins,
                              input int expSync, input int expOvr);
      int bad, nb;
      logic [8:0]  ep;
      logic [21:0] ew;
      check({tag, ".enCount"}, enQ.size(), oldPix + NPIX + LAG);
      bad = 0;
      foreach (enQ[i]) begin
         if (i < oldPix) ep = pix(i);
         else if (i < oldPix + NPIX) ep = pix(i - oldPix);
         else ep = '0;
         if (enQ[i] !== ep) bad++;
      end
      check({tag, ".enSeq"}, bad, 0);
      check({tag, ".winCount"}, winQ.size(), oldWins + NPIX);
      bad = 0;
      nb  = 0;
      foreach (winQ[i]) begin
         if (i < oldWins) ew = {1'b0, 1'b1, 10'd0, 10'(i)};
         else ew = winExp(i - oldWins);
         if (winQ[i] !== ew) bad++;
         if (i >= oldWins && winQ[i][20]) nb++;
      end
      check({tag, ".winSeq"}, bad, 0);
      check({tag, ".borders"}, nb, 20);
      check({tag, ".eofCount"}, eofCnt, 1);
      check({tag, ".syncErr"}, syncCnt, expSync);
      check({tag, ".overrun"}, ovrCnt, expOvr);
   endtask

   initial begin
      int sent;
      logic [21:0] w;
      drive(1'b0, 1'b0, '0);
      clearLog();

      for (int t = 0; t < NVEC; t++) begin
         tbl[t].pv     = (t < NPIX);
         tbl[t].sof    = (t == 0);
         tbl[t].rgb    = (t < NPIX) ? pix(t) : '0;
         tbl[t].expEn  = (t >= 1) && (t <= NPIX + LAG);
         tbl[t].expRGB = (t >= 1 && t <= NPIX) ? pix(t - 1) : '0;
         tbl[t].expWin = (t >= LAG + 2) && (t < LAG + 2 + NPIX);
         w = tbl[t].expWin ? winExp(t - LAG - 2) : '0;
         {tbl[t].expEof, tbl[t].expBorder, tbl[t].expRow, tbl[t].expCol} = w;
      end

      repeat (2) @(negedge clk);
      check("reset.outs", allOuts(), 0);
      rst = 1'b0;

      runTable("contig");
      repeat (5) step(1'b0, 1'b0, '0);

      // 50% duty on iPixValid
      clearLog();
      sent = 0;
      for (int c = 0; c < 600 && sent < NPIX; c++) begin
         if ($urandom_range(0, 1) == 1) begin
            step(1'b1, (sent == 0), pix(sent));
            sent++;
         end else begin
            step(1'b0, 1'b0, '0);
         end
      end
      check("rand.sent", sent, NPIX);
      repeat (20) step(1'b0, 1'b0, '0);
      checkStream("rand", 0, 0, 0, 0);

      // early SOF on source pixel 15
      clearLog();
      for (int i = 0; i < 15; i++) step(1'b1, (i == 0), pix(i));
      for (int i = 0; i < NPIX; i++) step(1'b1, (i == 0), pix(i));
      repeat (20) step(1'b0, 1'b0, '0);
      checkStream("early", 15, 5, 1, 0);

      // iPixValid held through FLUSH (one carrying iSof) and into IDLE
      clearLog();
      for (int i = 0; i < NPIX; i++) step(1'b1, (i == 0), pix(i));
      for (int i = 0; i < 14; i++) step(1'b1, (i == 3), 9'h1A5);
      repeat (20) step(1'b0, 1'b0, '0);
      checkStream("ovr", 0, 0, 0, 9);

      // reset mid-RUN at pixel 20
      clearLog();
      for (int i = 0; i < 20; i++) step(1'b1, (i == 0), pix(i));
      @(negedge clk);
      drive(1'b0, 1'b0, '0);
      check("rstMid.enBefore", bus.oEn, 1'b1);
      #2 rst = 1'b1;
      #1 check("rstMid.outs", allOuts(), 0);
      check("rstMid.eof", eofCnt, 0);
      check("rstMid.sync", syncCnt, 0);
      @(negedge clk);
      check("rstMid.held", allOuts(), 0);
      rst = 1'b0;
      runTable("afterRst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cell_sequencer.md
# cell_sequencer

Controller for the 3x3 pixel-window datapath in the video pipeline. It takes the raw 27 MHz pixel stream and generates the datapath's pixel enable and data. It tracks which source pixel sits at the centre of the current window and flags when the window outputs are meaningful. At end of frame it flushes the line buffers with black pixels, so every source pixel, including those on the last row, is presented once as a window centre.

## Interface
Parameters:
- WIDTH, 640, active pixels per line; multiple of 4, 4..1023
- HEIGHT, 480, active lines per frame; 2..1023
- LAG, WIDTH+1, number of datapath enables between a pixel entering and it reaching the window centre

Ports:
- iClk27  in  1  pixel clock, 27 MHz
- iRst  in  1  reset; asynchronous, active-high
- iPixValid  in  1  source pixel strobe, at most one pixel per cycle
- iSof  in  1  start of frame; qualified by iPixValid, marks pixel (0,0)
- iRGB  in  9  source pixel
- oEn  out  1  enable to the window datapath
- oRGB  out  9  pixel to the window datapath; valid when oEn=1
- oWinValid  out  1  window outputs hold a real centre pixel this cycle
- oCol  out  10  centre column, valid with oWinValid
- oRow  out  10  centre row, valid with oWinValid
- oBorder  out  1  centre is on the frame edge; valid with oWinValid
- oEof  out  1  one-cycle pulse coincident with the frame's final oWinValid
- oSyncErr  out  1  one-cycle pulse: frame aborted by an early iSof
- oOverrun  out  1  one-cycle pulse: source pixel dropped during FLUSH

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE:
  - iPixValid & iSof: accept the pixel, clear counters, go to RUN.
  - iPixValid without iSof: ignored, no oEn.
- RUN:
  - Each accepted pixel produces one oEn with oRGB=iRGB.
  - Input counter nIn counts 0..WIDTH*HEIGHT-1.
  - After accepting pixel WIDTH*HEIGHT-1, go to FLUSH.
- FLUSH:
  - Issues exactly LAG enables, one per cycle, with oRGB=0, independent of iPixValid.
  - Then returns to IDLE.
  - Any iPixValid in FLUSH is dropped and pulses oOverrun, including one carrying iSof.
- Enable counter nEn counts every oEn since SOF.
- Window tracking, on the cycle after an oEn with nEn >= LAG:
  - Assert oWinValid.
  - oCol/oRow give centre index nEn-LAG as (col,row), tracked with wrap counters, not division.
  - oCol wraps WIDTH-1 -> 0 and increments oRow.
- Exactly WIDTH*HEIGHT oWinValid pulses per complete frame.
- oBorder = (oCol==0) | (oCol==WIDTH-1) | (oRow==0) | (oRow==HEIGHT-1).
- oEof coincides with the window at (WIDTH-1, HEIGHT-1).
- iSof with iPixValid while in RUN (early SOF):
  - Pulse oSyncErr.
  - Discard window tracking; no further oWinValid from the old frame.
  - Treat the pixel as (0,0) of a new frame and stay in RUN with counters restarted.
- No backpressure: the datapath accepts an enable every cycle.

## Timing
- iPixValid at cycle t -> oEn/oRGB registered at t+1 -> oWinValid/oCol/oRow/oBorder at t+2.
- FLUSH enables occupy consecutive cycles starting the cycle after the last RUN enable.
- Gaps in iPixValid during RUN produce gaps in oEn; window tracking simply pauses.
- A new iSof accepted in the first IDLE cycle after FLUSH starts the next frame with no dead cycle beyond that.
- Reset, asynchronous:
  - State returns to IDLE.
  - oEn, oRGB, oWinValid, oCol, oRow, oBorder, oEof, oSyncErr and oOverrun all clear to 0.
  - Counters clear.
  - Reset mid-frame abandons the frame silently, with no oEof and no oSyncErr.
- Counter widths: nIn and nEn are 20 bits. oCol/oRow are 10 bits and never exceed WIDTH-1 / HEIGHT-1.

## Test plan
Bench parameters: WIDTH=8, HEIGHT=4, LAG=9.

- Contiguous frame of 32 pixels from t=0 with iSof at t=0:
  - 41 oEn pulses, the last 9 with oRGB=0.
  - First oWinValid at t=11 with (0,0).
  - 32 oWinValid pulses in raster order.
  - oEof with (7,3).
- Same frame with iPixValid at 50% random duty:
  - Identical sequence of oRGB values and window coordinates.
  - oEof still on the 32nd window.
- Border check: oBorder=1 for the 20 edge centres and 0 for the 12 interior centres (1..6, 1..2).
- Early iSof at source pixel 15:
  - oSyncErr pulses once.
  - No windows are emitted for old-frame pixels after the abort.
  - The next complete frame yields 32 windows.
- iPixValid held high throughout FLUSH: 9 oOverrun pulses, and no corruption of the flush oRGB=0 stream.
- Assert iRst mid-RUN at pixel 20:
  - All outputs are 0 immediately.
  - No oEof.
  - A following frame behaves exactly as in the first scenario.
